mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (fetch / data) arbiter onto a single-port memory
//            with fixed read latency and alternating-priority arbitration.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_last_cnt = 3'(MEM_LAT - 1);

  state_t     r_state;
  logic       r_owner_dm;
  logic       r_last_dm;
  logic       r_store;
  logic [2:0] r_cnt;
  logic       w_grant_dm;

  // Data side wins unless it was the previous grantee and fetch is also waiting.
  assign w_grant_dm = dm_req && (!if_req || !r_last_dm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner_dm <= 1'b0;
      r_last_dm  <= 1'b0;
      r_store    <= 1'b0;
      r_cnt      <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req || dm_req) begin
            r_owner_dm <= w_grant_dm;
            r_last_dm  <= w_grant_dm;
            r_store    <= w_grant_dm && dm_we;
            mem_en     <= 1'b1;
            mem_we     <= w_grant_dm && dm_we;
            mem_addr   <= w_grant_dm ? dm_addr : if_addr;
            mem_wdata  <= w_grant_dm ? dm_wdata : '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 3'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == c_last_cnt) begin
            // mem_rdata is valid only in this final wait cycle.
            if (r_owner_dm) begin
              if (!r_store) begin
                dm_rdata <= mem_rdata;
              end
              dm_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
